// File: rtl/song_draw_pkg.sv
// Shared constants for the song screen drawer: FSM encoding, palette, screen limits.
package song_draw_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Index 0 is lane 0.
    localparam logic [3:0][2:0] LANE_COLOUR = {3'b110, 3'b001, 3'b010, 3'b100};
    localparam logic [2:0] BG_COLOUR = 3'b000;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    // Counter width that still works for a modulus of 1.
    function automatic int unsigned cntWidth(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// Nested px/py/lane/row scan counters; exposes the value they take after this edge.
module cell_scan_counter
    import song_draw_pkg::*;
#(
    parameter int unsigned BLOCK_W = 8,
    parameter int unsigned BLOCK_H = 4,
    parameter int unsigned LANES   = 4,
    parameter int unsigned ROWS    = 8,
    localparam int unsigned PX_W   = cntWidth(BLOCK_W),
    localparam int unsigned PY_W   = cntWidth(BLOCK_H),
    localparam int unsigned LANE_W = cntWidth(LANES),
    localparam int unsigned ROW_W  = cntWidth(ROWS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [PX_W-1:0]   pxNext_c,
    output logic [PY_W-1:0]   pyNext_c,
    output logic [LANE_W-1:0] laneNext_c,
    output logic [ROW_W-1:0]  rowNext_c,
    output logic              lastPixel_c
);

    logic [PX_W-1:0]   px;
    logic [PY_W-1:0]   py;
    logic [LANE_W-1:0] lane;
    logic [ROW_W-1:0]  row;

    logic pxWrap_c, pyWrap_c, laneWrap_c, rowWrap_c;

    assign pxWrap_c    = (px   == PX_W'(BLOCK_W - 1));
    assign pyWrap_c    = (py   == PY_W'(BLOCK_H - 1));
    assign laneWrap_c  = (lane == LANE_W'(LANES - 1));
    assign rowWrap_c   = (row  == ROW_W'(ROWS - 1));
    assign lastPixel_c = pxWrap_c & pyWrap_c & laneWrap_c & rowWrap_c;

    // px innermost, then py, lane, row.
    always_comb begin
        pxNext_c   = px;
        pyNext_c   = py;
        laneNext_c = lane;
        rowNext_c  = row;
        if (clear) begin
            pxNext_c   = '0;
            pyNext_c   = '0;
            laneNext_c = '0;
            rowNext_c  = '0;
        end else if (enable) begin
            if (!pxWrap_c) begin
                pxNext_c = px + PX_W'(1);
            end else begin
                pxNext_c = '0;
                if (!pyWrap_c) begin
                    pyNext_c = py + PY_W'(1);
                end else begin
                    pyNext_c = '0;
                    if (!laneWrap_c) begin
                        laneNext_c = lane + LANE_W'(1);
                    end else begin
                        laneNext_c = '0;
                        rowNext_c  = rowWrap_c ? '0 : row + ROW_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            px   <= '0;
            py   <= '0;
            lane <= '0;
            row  <= '0;
        end else begin
            px   <= pxNext_c;
            py   <= pyNext_c;
            lane <= laneNext_c;
            row  <= rowNext_c;
        end
    end

endmodule

// File: rtl/song_screen_drawer.sv
// Repaints the note playfield through the VGA pixel port on each beat or song start,
// then pulses readyForSong back to the sequencer.
module song_screen_drawer
    import song_draw_pkg::*;
#(
    parameter int unsigned LANES   = 4,
    parameter int unsigned ROWS    = 8,
    parameter int unsigned BLOCK_W = 8,
    parameter int unsigned BLOCK_H = 4,
    parameter logic [7:0]  X0      = 8'd48,
    parameter logic [6:0]  Y0      = 7'd20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   beatIncremented,
    input  logic                   songDone,
    input  logic                   startSong,
    input  logic [LANES*ROWS-1:0]  noteWindow,
    output logic                   readyForSong,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   overrun
);

    localparam int unsigned NOTES  = LANES * ROWS;
    localparam int unsigned PX_W   = cntWidth(BLOCK_W);
    localparam int unsigned PY_W   = cntWidth(BLOCK_H);
    localparam int unsigned LANE_W = cntWidth(LANES);
    localparam int unsigned ROW_W  = cntWidth(ROWS);
    localparam int unsigned IDX_W  = cntWidth(NOTES);

    if ((32'(X0) + LANES * BLOCK_W > SCREEN_W) || (32'(Y0) + ROWS * BLOCK_H > SCREEN_H)) begin : gBadGeometry
        $error("song_screen_drawer: playfield does not fit on the 160x120 screen");
    end

    logic [1:0]       state, stateNext_c;
    logic [NOTES-1:0] snapshot, snapshotNext_c, drawWindow_c;
    logic             startPrev, startRise_c;
    logic             emit_c;
    logic             readyNext_c, plotNext_c, overrunNext_c;
    logic [7:0]       xNext_c;
    logic [6:0]       yNext_c;
    logic [2:0]       colourNext_c;

    logic [PX_W-1:0]   pxNext_c;
    logic [PY_W-1:0]   pyNext_c;
    logic [LANE_W-1:0] laneNext_c;
    logic [ROW_W-1:0]  rowNext_c;
    logic              lastPixel_c;
    logic [IDX_W-1:0]  bitIdx_c;

    cell_scan_counter #(
        .BLOCK_W (BLOCK_W),
        .BLOCK_H (BLOCK_H),
        .LANES   (LANES),
        .ROWS    (ROWS)
    ) uScan (
        .clock       (clock),
        .reset       (reset),
        .clear       (state == S_IDLE),
        .enable      (state == S_DRAW),
        .pxNext_c    (pxNext_c),
        .pyNext_c    (pyNext_c),
        .laneNext_c  (laneNext_c),
        .rowNext_c   (rowNext_c),
        .lastPixel_c (lastPixel_c)
    );

    assign startRise_c = startSong & ~startPrev;
    assign bitIdx_c    = IDX_W'(32'(rowNext_c) * LANES + 32'(laneNext_c));

    // Output registers load the pixel that the counters step to on this edge.
    always_comb begin
        stateNext_c    = state;
        snapshotNext_c = snapshot;
        drawWindow_c   = snapshot;
        overrunNext_c  = overrun;
        readyNext_c    = 1'b0;
        plotNext_c     = 1'b0;
        emit_c         = 1'b0;
        xNext_c        = x;
        yNext_c        = y;
        colourNext_c   = colour;

        case (state)
            S_IDLE: begin
                if (beatIncremented) begin
                    snapshotNext_c = noteWindow;
                    drawWindow_c   = noteWindow;
                    stateNext_c    = S_DRAW;
                    emit_c         = 1'b1;
                end else if (songDone && startRise_c) begin
                    snapshotNext_c = '0;
                    drawWindow_c   = '0;
                    stateNext_c    = S_DRAW;
                    emit_c         = 1'b1;
                end
            end
            S_DRAW: begin
                if (beatIncremented) overrunNext_c = 1'b1;
                if (lastPixel_c) begin
                    stateNext_c = S_DONE;
                    readyNext_c = 1'b1;
                end else begin
                    emit_c = 1'b1;
                end
            end
            S_DONE: begin
                if (beatIncremented) overrunNext_c = 1'b1;
                stateNext_c = S_IDLE;
            end
            default: stateNext_c = S_IDLE;
        endcase

        if (emit_c) begin
            plotNext_c   = 1'b1;
            xNext_c      = 8'(32'(X0) + 32'(laneNext_c) * BLOCK_W + 32'(pxNext_c));
            yNext_c      = 7'(32'(Y0) + 32'(rowNext_c) * BLOCK_H + 32'(pyNext_c));
            colourNext_c = drawWindow_c[bitIdx_c] ? LANE_COLOUR[2'(laneNext_c)] : BG_COLOUR;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            snapshot     <= '0;
            startPrev    <= 1'b1;
            readyForSong <= 1'b0;
            plot         <= 1'b0;
            overrun      <= 1'b0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
        end else begin
            state        <= stateNext_c;
            snapshot     <= snapshotNext_c;
            startPrev    <= startSong;
            readyForSong <= readyNext_c;
            plot         <= plotNext_c;
            overrun      <= overrunNext_c;
            x            <= xNext_c;
            y            <= yNext_c;
            colour       <= colourNext_c;
        end
    end

endmodule

// File: tb/tb_song_screen_drawer.sv
// Randomized and directed bench for song_screen_drawer against a frame-timeline model.
module tb_song_screen_drawer;

    localparam int N   = 1024;
    localparam int BW  = 8;
    localparam int BH  = 4;
    localparam int LN  = 4;

    logic        clock;
    logic        reset;
    logic        beatIncremented;
    logic        songDone;
    logic        startSong;
    logic [31:0] noteWindow;
    logic        readyForSong;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        overrun;

    song_screen_drawer dut (
        .clock           (clock),
        .reset           (reset),
        .beatIncremented (beatIncremented),
        .songDone        (songDone),
        .startSong       (startSong),
        .noteWindow      (noteWindow),
        .readyForSong    (readyForSong),
        .x               (x),
        .y               (y),
        .colour          (colour),
        .plot            (plot),
        .overrun         (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checkCount = 0;
    int passCount  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: mPhase is what the cycle after this edge shows (-1 idle, 0..N-1 pixel k, N ready pulse).
    int          mPhase = -1;
    logic        mStartPrev = 1'b1;
    logic        mOverrun = 1'b0;
    logic [31:0] mSnap = '0;
    logic        modelValid = 1'b0;
    logic        expPlot, expReady, expXYValid;
    int          expX, expY, expCol;
    int          laneCol [4] = '{4, 2, 1, 6};

    always @(posedge clock) begin
        if (!reset) begin
            mPhase = -1; mStartPrev = 1'b1; mOverrun = 1'b0;
            expPlot = 1'b0; expReady = 1'b0; expXYValid = 1'b1;
            expX = 0; expY = 0; expCol = 0;
        end else begin
            logic rise;
            rise = startSong && !mStartPrev;
            mStartPrev = startSong;
            if (mPhase < 0) begin
                if (beatIncremented) begin mSnap = noteWindow; mPhase = 0; end
                else if (songDone && rise) begin mSnap = '0; mPhase = 0; end
            end else begin
                if (beatIncremented) mOverrun = 1'b1;
                mPhase = (mPhase == N) ? -1 : mPhase + 1;
            end
            expReady   = (mPhase == N);
            expPlot    = (mPhase >= 0) && (mPhase < N);
            expXYValid = expPlot;
            if (expPlot) begin
                int px, py, ln, rw;
                px = mPhase % BW;
                py = (mPhase / BW) % BH;
                ln = (mPhase / (BW * BH)) % LN;
                rw = mPhase / (BW * BH * LN);
                expX   = (48 + ln * BW + px) % 256;
                expY   = (20 + rw * BH + py) % 128;
                expCol = mSnap[rw * LN + ln] ? laneCol[ln] : 0;
            end
        end
        modelValid = 1'b1;
    end

    int plotRun = 0;

    always @(negedge clock) begin
        if (modelValid) begin
            check("plot", 32'(plot), 32'(expPlot));
            check("readyForSong", 32'(readyForSong), 32'(expReady));
            check("overrun", 32'(overrun), 32'(mOverrun));
            if (expXYValid) begin
                check("x", 32'(x), 32'(expX));
                check("y", 32'(y), 32'(expY));
                check("colour", 32'(colour), 32'(expCol));
            end
            if (plot === 1'b1) plotRun++;
            if (readyForSong === 1'b1) begin
                check("frame_pixels", 32'(plotRun), 32'(N));
                plotRun = 0;
            end
            if (!reset) plotRun = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; beatIncremented = 1'b0; songDone = 1'b0; startSong = 1'b0; noteWindow = '0;
        repeat (3) tick();
        @(negedge clock);
        check("reset_plot", 32'(plot), 32'd0);
        check("reset_xy", 32'({x, y, colour}), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        tick();
        reset = 1'b1;
        repeat (2) tick();

        // Clear frame on start rise.
        songDone = 1'b1; startSong = 1'b1;
        tick();
        @(negedge clock);
        check("clear_first_x", 32'(x), 32'd48);
        check("clear_first_y", 32'(y), 32'd20);
        check("clear_first_plot", 32'(plot), 32'd1);
        repeat (N - 1) @(negedge clock);
        check("clear_last_x", 32'(x), 32'd79);
        check("clear_last_y", 32'(y), 32'd51);
        @(negedge clock);
        check("clear_ready", 32'(readyForSong), 32'd1);
        check("clear_ready_plot", 32'(plot), 32'd0);
        repeat (4) tick();
        startSong = 1'b0;

        // Row 0 lane 0 note.
        noteWindow = 32'h1; beatIncremented = 1'b1;
        tick();
        beatIncremented = 1'b0;
        @(negedge clock);
        check("note0_colour", 32'(colour), 32'd4);
        repeat (1030) tick();

        // Row 7 lane 3 note with window churn mid-frame.
        noteWindow = 32'h8000_0000; beatIncremented = 1'b1;
        tick();
        beatIncremented = 1'b0;
        repeat (N - 1) begin
            noteWindow = $urandom;
            tick();
        end
        @(negedge clock);
        check("note31_colour", 32'(colour), 32'd6);
        check("note31_x", 32'(x), 32'd79);
        repeat (5) tick();

        // Beat mid-frame raises overrun.
        noteWindow = 32'h1; beatIncremented = 1'b1;
        tick();
        beatIncremented = 1'b0;
        repeat (499) tick();
        beatIncremented = 1'b1;
        tick();
        beatIncremented = 1'b0;
        @(negedge clock);
        check("overrun_set", 32'(overrun), 32'd1);
        repeat (600) tick();
        check("overrun_held", 32'(overrun), 32'd1);

        // Beat and start rise together: beat frame wins.
        noteWindow = 32'h20; songDone = 1'b1; startSong = 1'b0;
        tick();
        startSong = 1'b1; beatIncremented = 1'b1;
        tick();
        beatIncremented = 1'b0;
        repeat (160) tick();
        @(negedge clock);
        check("both_colour", 32'(colour), 32'd2);
        check("both_x", 32'(x), 32'd56);
        check("both_y", 32'(y), 32'd24);
        repeat (900) tick();
        startSong = 1'b0;

        // Start rise while the sequencer is busy is ignored.
        songDone = 1'b0;
        tick();
        startSong = 1'b1;
        repeat (20) tick();
        check("busy_start_plot", 32'(plot), 32'd0);
        startSong = 1'b0;
        tick();

        // Reset mid-frame aborts it.
        noteWindow = 32'hA5A5_5A5A; beatIncremented = 1'b1;
        tick();
        beatIncremented = 1'b0;
        repeat (299) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        @(negedge clock);
        check("abort_plot", 32'(plot), 32'd0);
        check("abort_ready", 32'(readyForSong), 32'd0);
        tick();
        beatIncremented = 1'b1;
        tick();
        beatIncremented = 1'b0;
        repeat (1030) tick();

        // Random traffic.
        for (int i = 0; i < 15000; i++) begin
            beatIncremented = ($urandom_range(0, 399) == 0);
            noteWindow      = $urandom;
            if ($urandom_range(0, 49) == 0) songDone = ~songDone;
            if ($urandom_range(0, 99) == 0) startSong = ~startSong;
            reset = ($urandom_range(0, 2999) != 0);
            tick();
        end
        reset = 1'b1; beatIncremented = 1'b0;
        repeat (1100) tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
